// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and constants for the PLL lock / domain reset release sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } state_t;

    localparam int unsigned DOM_SRAM        = 0;
    localparam int unsigned DOM_PIXEL       = 1;
    localparam int unsigned DOM_TMDS        = 2;
    localparam int unsigned NUM_DOM_DEFAULT = 3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Single-bit two-flop synchronizer, synchronous active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock qualification sequencer with staggered per-domain reset release.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES     = 16,
    parameter int unsigned LOCK_TIMEOUT       = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STAGGER_CYCLES     = 64,
    parameter int unsigned MAX_RETRIES        = 7,
    parameter int unsigned NUM_DOM            = NUM_DOM_DEFAULT
) (
    input  logic               clk_50,
    input  logic               rst,
    input  logic               pll_lock,
    input  logic               restart_req,
    output logic               pll_rst,
    output logic [NUM_DOM-1:0] dom_rst,
    output logic               ready,
    output logic               fail,
    output logic [3:0]         retry_count,
    output logic [7:0]         loss_count,
    output logic [2:0]         state_dbg
);
    localparam int unsigned MAX_T = max_u(max_u(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                          max_u(LOCK_STABLE_CYCLES, STAGGER_CYCLES));
    localparam int unsigned CW = $clog2(MAX_T) + 1;
    localparam int unsigned IW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

    localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DOM - 1);

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [IW-1:0]      idx, idx_n;
    logic [NUM_DOM-1:0] dom_rst_n;
    logic [3:0]         retry_n;
    logic [7:0]         loss_n;
    logic               pll_rst_n, ready_n, fail_n;
    logic               lock_s;

    sync_2ff u_lock_sync (
        .clk (clk_50),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        dom_rst_n = dom_rst;
        retry_n   = retry_count;
        loss_n    = loss_count;

        if (restart_req) begin
            state_n   = RESET_PLL;
            cnt_n     = '0;
            idx_n     = '0;
            retry_n   = '0;
            dom_rst_n = '1;
        end else if ((state == RELEASE || state == RUN) && !lock_s) begin
            state_n   = RESET_PLL;
            cnt_n     = '0;
            idx_n     = '0;
            dom_rst_n = '1;
            if (loss_count != 8'hFF) loss_n = loss_count + 8'd1;
        end else begin
            case (state)
                RESET_PLL: begin
                    dom_rst_n = '1;
                    if (cnt == RST_LAST) begin
                        state_n = WAIT_LOCK;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_n = STABLE;
                        cnt_n   = '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt_n = '0;
                        if (retry_count == 4'(MAX_RETRIES)) begin
                            state_n = FAIL;
                        end else begin
                            state_n = RESET_PLL;
                            if (retry_count != 4'hF) retry_n = retry_count + 4'd1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_n = WAIT_LOCK;
                        cnt_n   = '0;
                    end else if (cnt == STABLE_LAST) begin
                        state_n = RELEASE;
                        cnt_n   = '0;
                        idx_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt == STAGGER_LAST) begin
                        cnt_n = '0;
                        for (int unsigned i = 0; i < NUM_DOM; i++) begin
                            if (idx == IW'(i)) dom_rst_n[i] = 1'b0;
                        end
                        if (idx == IDX_LAST) state_n = RUN;
                        else                 idx_n   = idx + 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                RUN: begin
                end
                FAIL: begin
                    dom_rst_n = '1;
                end
                default: begin
                    state_n   = RESET_PLL;
                    cnt_n     = '0;
                    idx_n     = '0;
                    dom_rst_n = '1;
                end
            endcase
        end

        // Level outputs follow the next state so they change on the same edge as the state.
        pll_rst_n = (state_n == RESET_PLL) || (state_n == FAIL);
        ready_n   = (state_n == RUN);
        fail_n    = (state_n == FAIL);
        if (state_n == RUN) retry_n = '0;
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state       <= RESET_PLL;
            cnt         <= '0;
            idx         <= '0;
            pll_rst     <= 1'b1;
            dom_rst     <= '1;
            ready       <= 1'b0;
            fail        <= 1'b0;
            retry_count <= '0;
            loss_count  <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            pll_rst     <= pll_rst_n;
            dom_rst     <= dom_rst_n;
            ready       <= ready_n;
            fail        <= fail_n;
            retry_count <= retry_n;
            loss_count  <= loss_n;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: countdown-style reference model plus directed timing pins.
module tb_pll_lock_sequencer;

    localparam int P_RST = 4, P_TO = 20, P_STB = 8, P_STG = 2, P_MAXR = 2, P_ND = 3;
    localparam int PH_PULSE = 0, PH_WAIT = 1, PH_QUAL = 2, PH_REL = 3, PH_RUN = 4, PH_DEAD = 5;

    logic       clk = 1'b0;
    logic       rst, pll_lock, restart_req;
    logic       pll_rst, ready, fail;
    logic [2:0] dom_rst, state_dbg;
    logic [3:0] retry_count;
    logic [7:0] loss_count;

    int n_tests = 0;
    int n_fail  = 0;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES     (P_RST),
        .LOCK_TIMEOUT       (P_TO),
        .LOCK_STABLE_CYCLES (P_STB),
        .STAGGER_CYCLES     (P_STG),
        .MAX_RETRIES        (P_MAXR),
        .NUM_DOM            (P_ND)
    ) dut (
        .clk_50      (clk),
        .rst         (rst),
        .pll_lock    (pll_lock),
        .restart_req (restart_req),
        .pll_rst     (pll_rst),
        .dom_rst     (dom_rst),
        .ready       (ready),
        .fail        (fail),
        .retry_count (retry_count),
        .loss_count  (loss_count),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: phase + remaining-cycle countdown + count of released domains.
    int m_phase, m_left, m_rel, m_retry, m_loss;
    bit m_valid = 1'b0;
    bit m_hist[$];

    always @(posedge clk) begin
        bit ls;
        if (rst) begin
            m_phase = PH_PULSE; m_left = P_RST; m_rel = 0; m_retry = 0; m_loss = 0;
            m_hist  = '{1'b0, 1'b0};
            m_valid = 1'b1;
        end else if (m_valid) begin
            ls = m_hist.pop_front();
            m_hist.push_back(pll_lock);
            if (restart_req) begin
                m_phase = PH_PULSE; m_left = P_RST; m_rel = 0; m_retry = 0;
            end else if ((m_phase == PH_REL || m_phase == PH_RUN) && !ls) begin
                m_phase = PH_PULSE; m_left = P_RST; m_rel = 0;
                m_loss  = (m_loss < 255) ? m_loss + 1 : 255;
            end else begin
                case (m_phase)
                    PH_PULSE: begin
                        m_left--;
                        if (m_left == 0) begin m_phase = PH_WAIT; m_left = P_TO; end
                    end
                    PH_WAIT: begin
                        if (ls) begin
                            m_phase = PH_QUAL; m_left = P_STB;
                        end else begin
                            m_left--;
                            if (m_left == 0) begin
                                if (m_retry == P_MAXR) m_phase = PH_DEAD;
                                else begin
                                    m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                                    m_phase = PH_PULSE; m_left = P_RST;
                                end
                            end
                        end
                    end
                    PH_QUAL: begin
                        if (!ls) begin
                            m_phase = PH_WAIT; m_left = P_TO;
                        end else begin
                            m_left--;
                            if (m_left == 0) begin m_phase = PH_REL; m_left = P_STG; m_rel = 0; end
                        end
                    end
                    PH_REL: begin
                        m_left--;
                        if (m_left == 0) begin
                            m_rel++;
                            m_left = P_STG;
                            if (m_rel == P_ND) m_phase = PH_RUN;
                        end
                    end
                    default: ;
                endcase
            end
            if (m_phase == PH_RUN) m_retry = 0;
        end
    end

    always @(negedge clk) begin
        int exp_dom;
        if (m_valid) begin
            exp_dom = (m_phase == PH_REL || m_phase == PH_RUN) ? ((7 << m_rel) & 7) : 7;
            check("pll_rst",   int'(pll_rst),     int'(m_phase == PH_PULSE || m_phase == PH_DEAD));
            check("dom_rst",   int'(dom_rst),     exp_dom);
            check("ready",     int'(ready),       int'(m_phase == PH_RUN));
            check("fail",      int'(fail),        int'(m_phase == PH_DEAD));
            check("retry",     int'(retry_count), m_retry);
            check("loss",      int'(loss_count),  m_loss);
            check("state_dbg", int'(state_dbg),   m_phase);
        end
    end

    initial begin
        int hi, t0, t1, t2, tr, tf, r30, r71, viol, kd, kr, s9, s10, run_left;
        bit found;
        rst = 1'b1; restart_req = 1'b0; pll_lock = 1'b1;

        // Nominal bring-up with lock always present
        step(); step(); rst = 1'b0;
        hi = 0; t0 = -1; t1 = -1; t2 = -1; tr = -1;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) step();
            if (pll_rst) hi++;
            if (dom_rst == 3'b110 && t0 < 0) t0 = k;
            if (dom_rst == 3'b100 && t1 < 0) t1 = k;
            if (dom_rst == 3'b000 && t2 < 0) t2 = k;
            if (ready && tr < 0) tr = k;
        end
        check("nom_pll_rst_len", hi, 4);
        check("nom_dom0_fall", t0, 15);
        check("nom_dom1_fall", t1, 17);
        check("nom_dom2_fall", t2, 19);
        check("nom_ready_rise", tr, 19);
        check("nom_retry", int'(retry_count), 0);
        check("nom_loss", int'(loss_count), 0);

        // Lock chatter while qualifying
        rst = 1'b1; step(); step(); rst = 1'b0;
        hi = 0; tr = -1; s9 = -1; s10 = -1;
        for (int k = 0; k < 50; k++) begin
            if (k > 0) step();
            if (pll_rst) hi++;
            if (ready && tr < 0) tr = k;
            if (k == 9)  s9  = int'(state_dbg);
            if (k == 10) s10 = int'(state_dbg);
            if (k == 7)  pll_lock = 1'b0;
            if (k == 10) pll_lock = 1'b1;
        end
        check("chat_state_stable", s9, 2);
        check("chat_state_wait", s10, 1);
        check("chat_pll_rst_len", hi, 4);
        check("chat_ready_rise", tr, 27);
        check("chat_retry", int'(retry_count), 0);

        // Permanent no-lock: three attempts then FAIL
        pll_lock = 1'b0;
        rst = 1'b1; step(); step(); rst = 1'b0;
        hi = 0; tf = -1; r30 = -1; r71 = -1; viol = 0;
        for (int k = 0; k < 90; k++) begin
            if (k > 0) step();
            if (k < 72 && pll_rst) hi++;
            if (fail && tf < 0) tf = k;
            if (k == 30) r30 = int'(retry_count);
            if (k == 71) r71 = int'(retry_count);
            if (k >= 72 && (!pll_rst || dom_rst != 3'b111)) viol++;
        end
        check("to_pll_rst_total", hi, 12);
        check("to_fail_rise", tf, 72);
        check("to_retry_mid", r30, 1);
        check("to_retry_last", r71, 2);
        check("to_fail_hold", viol, 0);

        // Restart out of FAIL with lock available
        pll_lock = 1'b1; restart_req = 1'b1;
        step();
        restart_req = 1'b0;
        check("rs_fail_clear", int'(fail), 0);
        check("rs_retry_clear", int'(retry_count), 0);
        tr = -1;
        for (int k = 1; k < 40; k++) begin
            step();
            if (ready && tr < 0) tr = k;
        end
        check("rs_ready_rise", tr, 19);

        // One-cycle lock drop while running
        pll_lock = 1'b0;
        hi = 0; kd = -1; kr = -1; tr = -1;
        for (int k = 1; k < 40; k++) begin
            step();
            if (k == 1) pll_lock = 1'b1;
            if (pll_rst) hi++;
            if (dom_rst == 3'b111 && kd < 0) begin
                kd = k;
                check("loss_count_after", int'(loss_count), 1);
            end
            if (!ready && kr < 0) kr = k;
            if (ready && kr >= 0 && tr < 0) tr = k;
        end
        check("loss_dom_all", kd, 3);
        check("loss_ready_fall", kr, 3);
        check("loss_pll_rst_len", hi, 4);
        check("loss_ready_again", tr, 22);

        // Reset arriving mid-release
        pll_lock = 1'b0; step(); pll_lock = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (dom_rst == 3'b110) found = 1'b1;
        end
        check("mid_found_release", int'(found), 1);
        check("mid_loss_before", int'(loss_count), 2);
        rst = 1'b1; step();
        check("mid_dom_rst", int'(dom_rst), 7);
        check("mid_pll_rst", int'(pll_rst), 1);
        check("mid_ready", int'(ready), 0);
        check("mid_loss", int'(loss_count), 0);
        check("mid_state", int'(state_dbg), 0);
        rst = 1'b0;

        // Randomized lock patterns with occasional restart and reset
        run_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                pll_lock = ($urandom_range(0, 3) != 0);
                run_left = pll_lock ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 30));
            end
            run_left--;
            restart_req = ($urandom_range(0, 199) == 0);
            rst         = ($urandom_range(0, 499) == 0);
            step();
        end
        restart_req = 1'b0; rst = 1'b0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Runs on the free-running 50 MHz board clock and owns the ECP5 PLL reset input.
- Pulses the PLL reset, waits for lock with a timeout, and retries up to a limit.
- Qualifies lock as stable, then releases the per-domain reset requests (SRAM 100 MHz, pixel, TMDS) one at a time in a fixed order.
- Detects lock loss at any point and restarts the sequence. Per-domain reset synchronizers sit outside this block.

Parameters:
- PLL_RST_CYCLES, 16: cycles pll_rst is held high per attempt (must be >=1).
- LOCK_TIMEOUT, 50000: cycles to wait for lock before a retry (1 ms at 50 MHz).
- LOCK_STABLE_CYCLES, 1024: cycles of continuous synced lock required before release.
- STAGGER_CYCLES, 64: cycles between successive domain reset releases (must be >=1).
- MAX_RETRIES, 7: timeout retries allowed before FAIL.
- NUM_DOM, 3: number of domain reset outputs; index 0 is released first.

Ports:
- clk_50, in, 1: 50 MHz board clock; the only clock.
- rst, in, 1: synchronous, active-high reset.
- pll_lock, in, 1: PLL LOCK pin; asynchronous, synchronized internally.
- restart_req, in, 1: single-cycle pulse forcing a full restart.
- pll_rst, out, 1: PLL RST input, active-high.
- dom_rst, out, NUM_DOM: active-high per-domain reset requests.
- ready, out, 1: high when all domains are released and the block is in RUN.
- fail, out, 1: high in FAIL.
- retry_count, out, 4: timeouts in the current bring-up; saturating.
- loss_count, out, 8: lock-loss events since rst; saturating at 255.
- state_dbg, out, 3: encoded current state.

Behaviour:
- Reset values (rst high on the clock edge): state=RESET_PLL, cnt=0, idx=0, pll_rst=1, dom_rst=all 1, ready=0, fail=0, retry_count=0, loss_count=0, synchronizer flops=0.
- All outputs are registered.
- lock_s is pll_lock through 2 flops (2-cycle latency). Every decision uses lock_s only.
- Priority each cycle: restart_req, then lock loss, then timer/state transitions.
- restart_req in any state, including FAIL: next state RESET_PLL, cnt=0, retry_count=0, fail=0, ready=0, dom_rst=all 1, pll_rst=1.
- RESET_PLL:
  - pll_rst=1, dom_rst=all 1, ready=0.
  - cnt counts 0..PLL_RST_CYCLES-1. At the terminal count, go to WAIT_LOCK with cnt=0.
  - pll_rst is 0 from the first WAIT_LOCK cycle, so it is high exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK:
  - If lock_s=1, go to STABLE with cnt=0.
  - Else, at cnt==LOCK_TIMEOUT-1: if retry_count==MAX_RETRIES, go to FAIL; otherwise retry_count+1 and go to RESET_PLL.
- STABLE:
  - If lock_s=0, go to WAIT_LOCK with cnt=0. The timeout window restarts and retry_count is not incremented.
  - At cnt==LOCK_STABLE_CYCLES-1, go to RELEASE with cnt=0, idx=0.
- RELEASE:
  - cnt counts 0..STAGGER_CYCLES-1. At the terminal count, clear dom_rst[idx], idx+1, cnt=0.
  - After dom_rst[NUM_DOM-1] clears, go to RUN. ready=1 in the same cycle the last dom_rst goes low.
  - lock_s=0 is a lock loss (see below).
- RUN:
  - ready=1, retry_count cleared to 0.
  - lock_s=0 is a lock loss.
- Lock loss (RELEASE or RUN, lock_s=0):
  - Next cycle: dom_rst=all 1, ready=0, loss_count+1 (saturating).
  - State goes to RESET_PLL with cnt=0.
- FAIL:
  - pll_rst=1, dom_rst=all 1, fail=1, ready=0.
  - Exit only on rst or restart_req.
- Counter width: $clog2 of the maximum of the timing parameters, plus 1 bit. No counter wraps, because every counter is reset at its terminal compare.
- retry_count saturates at 15.
- Release ordering is strictly ascending index; no two dom_rst bits deassert in the same cycle.

Decomposition:
- pll_seq_pkg contains:
  - state enum: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAIL=5 (this encoding drives state_dbg);
  - domain index constants: DOM_SRAM=0, DOM_PIXEL=1, DOM_TMDS=2;
  - default NUM_DOM=3.
- One sub-module: sync_2ff, a single-bit 2-flop synchronizer with synchronous active-high reset to 0, used for pll_lock.

Test Plan:
Bench parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, STAGGER_CYCLES=2, MAX_RETRIES=2, NUM_DOM=3.
- Nominal bring-up: pll_lock=1 constantly, rst released.
  - pll_rst high exactly 4 cycles.
  - dom_rst[0], [1], [2] fall one at a time, 2 cycles apart, in that order.
  - ready rises with dom_rst[2]; retry_count=0; loss_count=0.
- Timeout to FAIL: pll_lock=0 forever.
  - 3 pll_rst pulses of 4 cycles each, with 20-cycle gaps; retry_count goes 0, 1, 2.
  - fail=1 after the third timeout; pll_rst then stays 1 and dom_rst stays 7.
- Lock chatter in STABLE: pll_lock drops for 3 cycles after 5 stable cycles.
  - State returns to WAIT_LOCK; no pll_rst pulse; retry_count unchanged.
  - Release happens 8 full cycles after lock is regained.
- Lock loss in RUN: from RUN, pll_lock=0 for 1 cycle.
  - dom_rst=7 and ready=0 within 3 cycles of the pin edge; loss_count=1; a new 4-cycle pll_rst pulse follows.
  - With lock restored, all domains are released again.
- Restart from FAIL: in FAIL, pulse restart_req for 1 cycle.
  - fail=0 next cycle; retry_count=0; a fresh sequence starts.
  - With lock=1, ready is reached with normal timing.
- Reset mid-RELEASE: assert rst after dom_rst[0] clears.
  - Next cycle: dom_rst=7, pll_rst=1, ready=0, loss_count=0, state_dbg=0.
